reg_array: RTL



---
 rtl/regfile_pkg.sv | 10 +
 rtl/reg_array_decoder5to32.sv | 34 +++
 rtl/reg_array.sv | 41 ++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the packed register bus type used by
// the storage stage and the read multiplexers.
package regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int ZERO_REG = 31;

    typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_bus_t;
endpackage

// File: rtl/reg_array_decoder5to32.sv
// 5-to-32 one-hot decoder built from two 2-to-4 decoders and a 1-to-2
// decoder combined with AND gates; all outputs low when en is low.
module decoder5to32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   in,
    input  logic                en,
    output logic [NUM_REGS-1:0] out
);
    logic [3:0] lo;
    logic [3:0] mid;
    logic [1:0] hi;
    logic [4:0] n;

    assign n = ~in;

    assign lo[0] = n[1]  & n[0];
    assign lo[1] = n[1]  & in[0];
    assign lo[2] = in[1] & n[0];
    assign lo[3] = in[1] & in[0];

    assign mid[0] = n[3]  & n[2];
    assign mid[1] = n[3]  & in[2];
    assign mid[2] = in[3] & n[2];
    assign mid[3] = in[3] & in[2];

    assign hi[0] = n[4];
    assign hi[1] = in[4];

    // Gating with en first keeps unknown addresses from reaching the outputs.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign out[i] = en & hi[i/16] & mid[(i/4)%4] & lo[i%4];
    end
endmodule

// File: rtl/reg_array.sv
// Storage stage of the 32 x 64-bit register file: one write port, full
// packed register bus out, X31 hardwired to zero.
module reg_array
    import regfile_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             RegWrite,
    input  logic [ADDR_W-1:0]                WriteRegister,
    input  logic [DATA_W-1:0]                WriteData,
    output logic [NUM_REGS-1:0][DATA_W-1:0]  regs
);
    logic [NUM_REGS-1:0] en;

    decoder5to32 u_dec (
        .in  (WriteRegister),
        .en  (RegWrite),
        .out (en)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            logic unused_zero_en;
            assign unused_zero_en = en[i];
            assign regs[i]        = '0;
        end else begin : g_dff
            logic [DATA_W-1:0] q;
            logic [DATA_W-1:0] d;

            // Enable realised as a 2:1 select; reset wins over a same-cycle write.
            assign d = en[i] ? WriteData : q;

            always_ff @(posedge clk) begin
                if (reset) q <= '0;
                else       q <= d;
            end

            assign regs[i] = q;
        end
    end
endmodule
